// File: rtl/sqrt_arbiter_if.sv
// sqrt_arbiter_if: requester and result signal bundle for sqrt_arbiter.
interface sqrt_arbiter_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]   req;
  logic [NREQ*8-1:0] req_data;
  logic [NREQ-1:0]   gnt;
  logic              busy;
  logic              res_valid;
  logic              res_ready;
  logic [15:0]       res_data;
  logic [2:0]        res_id;
  modport master (output req, req_data, res_ready, input gnt, busy, res_valid, res_data, res_id);
  modport slave (input req, req_data, res_ready, output gnt, busy, res_valid, res_data, res_id);
endinterface

// File: rtl/sqrt_arbiter.sv
// sqrt_arbiter: shares one 8-bit -> 8.8 square-root datapath among NREQ requesters.
// SQRT_ARB_RR_EN selects round-robin arbitration; undefined gives fixed lowest-index priority.
module sqrt_arbiter #(
  parameter int NREQ = 4
) (
  input logic           clk,
  input logic           rst_n,
  sqrt_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, CALC, HOLD} state_t;
  state_t            state_q, state_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [7:0]        op_q, op_d;
  logic [2:0]        id_q, id_d;
  logic [2:0]        res_id_q, res_id_d;
  logic [15:0]       res_data_q, res_data_d;
  logic              res_valid_q, res_valid_d;
  logic              found;
  logic [2:0]        win, lo_win;
  logic [7:0]        win_data, lo_data;
`ifdef SQRT_ARB_RR_EN
  logic [2:0]        ptr_q, ptr_d;
  logic              hit;
  logic [2:0]        hit_win;
  logic [7:0]        hit_data;
`endif

  // Bit-pair restoring square root of {a, 16'h0}; result fits in 12 bits.
  function automatic logic [11:0] isqrt(input logic [7:0] a);
    logic [23:0] num, res, b;
    num = {a, 16'h0000};
    res = '0;
    b = 24'h40_0000;
    for (int i = 0; i < 12; i++) begin
      if (num >= res + b) begin
        num = num - (res + b);
        res = (res >> 1) + b;
      end else begin
        res = res >> 1;
      end
      b = b >> 2;
    end
    return res[11:0];
  endfunction

  always_comb begin
    found = 1'b0;
    lo_win = '0;
    lo_data = '0;
`ifdef SQRT_ARB_RR_EN
    hit = 1'b0;
    hit_win = '0;
    hit_data = '0;
`endif
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (bus.req[k]) begin
        found = 1'b1;
        lo_win = 3'(k);
        lo_data = bus.req_data[8*k +: 8];
      end
`ifdef SQRT_ARB_RR_EN
      if (bus.req[k] && 3'(k) >= ptr_q) begin
        hit = 1'b1;
        hit_win = 3'(k);
        hit_data = bus.req_data[8*k +: 8];
      end
`endif
    end
`ifdef SQRT_ARB_RR_EN
    win = hit ? hit_win : lo_win;
    win_data = hit ? hit_data : lo_data;
`else
    win = lo_win;
    win_data = lo_data;
`endif
  end

  always_comb begin
    state_d = state_q;
    gnt_d = '0;
    op_d = op_q;
    id_d = id_q;
    res_data_d = res_data_q;
    res_id_d = res_id_q;
    res_valid_d = res_valid_q;
`ifdef SQRT_ARB_RR_EN
    ptr_d = ptr_q;
`endif
    unique case (state_q)
      IDLE: if (found) begin
        state_d = CALC;
        gnt_d = NREQ'(1) << win;
        op_d = win_data;
        id_d = win;
`ifdef SQRT_ARB_RR_EN
        ptr_d = (win == 3'(NREQ - 1)) ? 3'd0 : win + 3'd1;
`endif
      end
      CALC: begin
        state_d = HOLD;
        res_data_d = {4'h0, isqrt(op_q)};
        res_id_d = id_q;
        res_valid_d = 1'b1;
      end
      HOLD: if (bus.res_ready) begin
        state_d = IDLE;
        res_valid_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q <= '0;
      op_q <= '0;
      id_q <= '0;
      res_data_q <= '0;
      res_id_q <= '0;
      res_valid_q <= 1'b0;
`ifdef SQRT_ARB_RR_EN
      ptr_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      gnt_q <= gnt_d;
      op_q <= op_d;
      id_q <= id_d;
      res_data_q <= res_data_d;
      res_id_q <= res_id_d;
      res_valid_q <= res_valid_d;
`ifdef SQRT_ARB_RR_EN
      ptr_q <= ptr_d;
`endif
    end
  end

  assign bus.gnt = gnt_q;
  assign bus.busy = state_q != IDLE;
  assign bus.res_valid = res_valid_q;
  assign bus.res_data = res_data_q;
  assign bus.res_id = res_id_q;
endmodule

// File: tb/tb_sqrt_arbiter.sv
// tb_sqrt_arbiter: table vectors, corner sequences and random traffic against a reference model.
module tb_sqrt_arbiter;
  localparam int N = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_cmp = 0;
  int n_bad = 0;
  int ptr = 0;
  sqrt_arbiter_if #(.NREQ(N)) bus ();
  sqrt_arbiter #(.NREQ(N)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0]   r;
    logic [N*8-1:0] d;
    int             hold;
    int             id;
    int             res;
  } vec_t;
  vec_t tbl[8];

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    chk("gnt_valid_exclusive", int'(bus.gnt != '0 && bus.res_valid), 0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_gnt"}, int'(bus.gnt), 0);
    chk({tag, "_busy"}, int'(bus.busy), 0);
    chk({tag, "_valid"}, int'(bus.res_valid), 0);
    chk({tag, "_data"}, int'(bus.res_data), 0);
    chk({tag, "_id"}, int'(bus.res_id), 0);
  endtask

  function automatic int ref_sqrt(input int a);
    int x = a * 65536;
    int r = $rtoi($sqrt(real'(x)));
    while (r * r > x) r--;
    while ((r + 1) * (r + 1) <= x) r++;
    return r;
  endfunction

  function automatic int ref_win(input logic [N-1:0] r, input int p);
`ifdef SQRT_ARB_RR_EN
    for (int k = 0; k < N; k++) if (r[(p + k) % N]) return (p + k) % N;
`else
    for (int k = 0; k < N; k++) if (r[k]) return k;
`endif
    return -1;
  endfunction

  task automatic do_reset();
    bus.req = '0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    ptr = 0;
  endtask

  // One full request/result exchange starting in IDLE; checks against the model.
  task automatic txn(input logic [N-1:0] r, input logic [N*8-1:0] d, input int hold, input bit keep,
                     output int got_id, output int got_res, output longint tg);
    int w;
    int e;
    w = ref_win(r, ptr);
    e = ref_sqrt(int'(d[8*w +: 8]));
    bus.req = r;
    bus.req_data = d;
    bus.res_ready = (hold == 0);
    chk("idle_busy", int'(bus.busy), 0);
    step();
    tg = $time;
    chk("gnt", int'(bus.gnt), 1 << w);
    chk("gnt_busy", int'(bus.busy), 1);
    if (!keep) bus.req[w] = 1'b0;
    step();
    chk("valid", int'(bus.res_valid), 1);
    chk("data", int'(bus.res_data), e);
    chk("id", int'(bus.res_id), w);
    got_id = int'(bus.res_id);
    got_res = int'(bus.res_data);
    for (int i = 0; i < hold; i++) begin
      step();
      chk("hold_valid", int'(bus.res_valid), 1);
      chk("hold_data", int'(bus.res_data), e);
      chk("hold_id", int'(bus.res_id), w);
      chk("hold_gnt", int'(bus.gnt), 0);
    end
    bus.res_ready = 1'b1;
    step();
    chk("drop_valid", int'(bus.res_valid), 0);
    chk("drop_busy", int'(bus.busy), 0);
    ptr = (w + 1) % N;
  endtask

  initial begin
    int id, res;
    longint tg, tprev;
    logic [N*8-1:0] d;
    logic [N-1:0] r;
    tbl[0] = '{4'b0100, 32'h0064_0000, 0, 2, 'h0A00};
    tbl[1] = '{4'b0001, 32'h0000_0000, 0, 0, 'h0000};
    tbl[2] = '{4'b0001, 32'h0000_0001, 2, 0, 'h0100};
    tbl[3] = '{4'b0001, 32'h0000_0002, 0, 0, 'h016A};
    tbl[4] = '{4'b0001, 32'h0000_0004, 1, 0, 'h0200};
    tbl[5] = '{4'b0001, 32'h0000_00FF, 0, 0, 'h0FF7};
    tbl[6] = '{4'b1000, 32'h9000_0000, 3, 3, 'h0C00};
    tbl[7] = '{4'b0010, 32'h0000_0900, 0, 1, 'h0300};
    bus.req = '0;
    bus.req_data = '0;
    bus.res_ready = 1'b0;
    step();
    step();
    chk_zero("reset");
    rst_n = 1'b1;
    step();
    foreach (tbl[i]) begin
      txn(tbl[i].r, tbl[i].d, tbl[i].hold, 1'b0, id, res, tg);
      chk("tbl_id", id, tbl[i].id);
      chk("tbl_res", res, tbl[i].res);
    end
    // All requesters held high with res_ready tied high.
    do_reset();
    d = 32'h4019_6410;
    for (int i = 0; i < 5; i++) begin
      txn(4'b1111, d, 0, 1'b1, id, res, tg);
`ifdef SQRT_ARB_RR_EN
      chk("seq_id", id, i % 4);
`else
      chk("seq_id", id, 0);
`endif
      if (i > 0) chk("turnaround", int'(tg - tprev), 30);
      tprev = tg;
    end
    bus.req = '0;
    step();
    // Backpressure with another request pending.
    txn(4'b0011, 32'h0000_1951, 10, 1'b0, id, res, tg);
    txn(bus.req, bus.req_data, 0, 1'b0, id, res, tg);
    // Withdrawal of requester 1 while requester 0 is being served.
    do_reset();
    bus.req = 4'b0011;
    bus.req_data = 32'h1100_2233;
    bus.res_ready = 1'b0;
    step();
    chk("wd_gnt0", int'(bus.gnt), 'b0001);
    bus.req = 4'b0010;
    step();
    chk("wd_id0", int'(bus.res_id), 0);
    bus.req = 4'b1000;
    step();
    chk("wd_hold_gnt", int'(bus.gnt), 0);
    bus.res_ready = 1'b1;
    step();
    chk("wd_idle_gnt", int'(bus.gnt), 0);
    step();
    chk("wd_gnt3", int'(bus.gnt), 'b1000);
    bus.req = '0;
    step();
    chk("wd_id3", int'(bus.res_id), 3);
    chk("wd_data3", int'(bus.res_data), ref_sqrt(8'h11));
    step();
    // Reset during CALC.
    do_reset();
    bus.req = 4'b0100;
    bus.req_data = 32'h0064_0000;
    step();
    chk("rc_gnt", int'(bus.gnt), 'b0100);
    bus.req = '0;
    #1 rst_n = 1'b0;
    #1 chk_zero("rst_calc");
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rc_after_valid", int'(bus.res_valid), 0);
      chk("rc_after_gnt", int'(bus.gnt), 0);
    end
    // Reset during HOLD; afterwards the round-robin pointer must restart at 0.
    bus.req = 4'b0100;
    bus.res_ready = 1'b0;
    step();
    bus.req = '0;
    step();
    chk("rh_valid", int'(bus.res_valid), 1);
    #1 rst_n = 1'b0;
    #1 chk_zero("rst_hold");
    step();
    rst_n = 1'b1;
    ptr = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rh_after_valid", int'(bus.res_valid), 0);
    end
    txn(4'b1011, 32'h0405_0607, 0, 1'b0, id, res, tg);
    chk("rh_ptr_restart", id, 0);
    // Random traffic.
    for (int i = 0; i < 40; i++) begin
      r = N'($urandom_range(1, (1 << N) - 1));
      d = $urandom;
      txn(r, d, int'($urandom_range(0, 3)), 1'b0, id, res, tg);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
